// File: rtl/exotiny_conout.sv
// exotiny_conout: console-output peripheral on the exotiny register bus.
// CPU writes bytes to TXDATA. They are queued in a small FIFO and sent 8N1 on tx_o.
// The written byte stream is also watched for the "DONE" and "ERR" end-of-test tokens.
// Either token raises a sticky flag that the CPU can clear through CTRL.
module exotiny_conout #(
    parameter int CLKDIV    = 434,
    parameter int FIFODEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        tx_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int AW = $clog2(FIFODEPTH);
    localparam int CW = $clog2(CLKDIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd3;

    localparam logic [31:0]   TOK_DONE = 32'h444F_4E45;
    localparam logic [23:0]   TOK_ERR  = 24'h45_5252;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [7:0]    fifo_mem_r [FIFODEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic [31:0]   sr_r;
    logic          done_r;
    logic          err_r;
    logic          ack_r;
    logic [31:0]   rdat_r;

    logic [2:0]    adr_idx_s;
    logic          req_s;
    logic          wr_txdata_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          clear_s;
    logic [AW:0]   level_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          busy_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    // Address bits [1:0] and the upper data bytes are not decoded.
    assign unused_s = ^{wb_adr_i[1:0], wb_dat_i[31:8]};

    // FIFO occupancy and flags derived from the wrap-bit pointers.
    always_comb begin
        level_s      = wr_ptr_r - rd_ptr_r;
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        busy_s       = (state_r != ST_IDLE) || !fifo_empty_s;
    end

    // Bus request decode. A TXDATA write into a full FIFO is held off without an ack.
    always_comb begin
        adr_idx_s   = wb_adr_i[4:2];
        req_s       = wb_stb_i & ~ack_r;
        wr_txdata_s = req_s & wb_we_i & (adr_idx_s == REG_TXDATA);
        accept_s    = req_s & ~(wr_txdata_s & fifo_full_s);
        push_s      = wr_txdata_s & ~fifo_full_s;
        clear_s     = accept_s & wb_we_i & (adr_idx_s == REG_CTRL) & wb_dat_i[0];
        pop_s       = (state_r == ST_IDLE) & ~fifo_empty_s;
    end

    // Read-data mux: only STATUS returns content, everything else reads zero.
    always_comb begin
        status_s = {16'h0000, 8'(level_s), 4'h0, busy_s, fifo_full_s, err_r, done_r};
        if (!wb_we_i && (adr_idx_s == REG_STATUS)) begin
            rdata_s = status_s;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Registered acknowledge: a one-cycle pulse per accepted request, with data only during the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r  <= 1'b0;
            rdat_r <= 32'h0000_0000;
        end else if (accept_s) begin
            ack_r  <= 1'b1;
            rdat_r <= rdata_s;
        end else begin
            ack_r  <= 1'b0;
            rdat_r <= 32'h0000_0000;
        end
    end

    // FIFO storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= wb_dat_i[7:0];
        end
    end

    // FIFO pointers. Push happens on the ack edge. Pop happens when the transmitter picks up a byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // 8N1 transmitter. tx_r is updated together with each state change, so the line has no glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    // Token watcher. Accepted bytes shift into sr_r, and the flags latch one cycle after sr_r matches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_r   <= 32'h0000_0000;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (clear_s) begin
            sr_r   <= 32'h0000_0000;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (push_s) begin
                sr_r <= {sr_r[23:0], wb_dat_i[7:0]};
            end
            done_r <= done_r | (sr_r == TOK_DONE);
            err_r  <= err_r | (sr_r[23:0] == TOK_ERR);
        end
    end

    assign wb_ack_o = ack_r;
    assign wb_dat_o = rdat_r;
    assign tx_o     = tx_r;
    assign done_o   = done_r;
    assign err_o    = err_r;

endmodule
